// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-wide UART transmitter.
// A one-entry holding register sits in front of the bit shifter, so a new
// byte can wait while the current frame is still on the line. This lets
// frames go out back to back with no idle gap between them.
// Frame format: start bit, 8 data bits LSB first, optional parity bit,
// then 1 or 2 stop bits.
module uart_byte_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,        // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1         // 1 or 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_state,
    output logic       tx_done,
    output logic       rs232_tx
);

    // The bit period is a multiple of 16 clocks. This matches the bit time
    // that the 16x oversampling receiver assumes.
    localparam int          BIT_CLKS = 16 * ((CLK_FREQ / BAUD_RATE) >> 4);
    localparam logic [15:0] BIT_LAST = 16'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    tx_state_t   state_reg,     state_next;
    logic [15:0] baud_cnt_reg,  baud_cnt_next;
    logic [2:0]  bit_idx_reg,   bit_idx_next;
    logic        stop_cnt_reg,  stop_cnt_next;
    logic [7:0]  shift_reg,     shift_next;
    logic        parity_reg,    parity_next;
    logic [7:0]  hold_data_reg, hold_data_next;
    logic        hold_full_reg, hold_full_next;
    logic        tx_reg,        tx_next;
    logic        done_reg,      done_next;

    logic        bit_end;
    logic        stop_last;
    logic        accept;
    logic        hold_parity;

    // XOR chain over the held byte gives its even-parity bit. This value is
    // ready at the moment the byte moves into the shifter.
    logic [8:0]  par_chain;
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_par_chain
            assign par_chain[gi + 1] = par_chain[gi] ^ hold_data_reg[gi];
        end
    endgenerate

    // Odd parity is the complement of the even-parity bit.
    assign hold_parity = (PARITY == 1) ? ~par_chain[8] : par_chain[8];

    assign bit_end   = (baud_cnt_reg == BIT_LAST);
    assign stop_last = (STOP_BITS == 2) ? stop_cnt_reg : 1'b1;
    assign accept    = tx_valid && !hold_full_reg;

    assign tx_ready  = !hold_full_reg;
    assign tx_state  = (state_reg != ST_IDLE);
    assign tx_done   = done_reg;
    assign rs232_tx  = tx_reg;

    // State, counter, shifter and holding-register update. Reset takes
    // priority over everything else, including a pending tx_valid.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= ST_IDLE;
            baud_cnt_reg  <= 16'd0;
            bit_idx_reg   <= 3'd0;
            stop_cnt_reg  <= 1'b0;
            shift_reg     <= 8'd0;
            parity_reg    <= 1'b0;
            hold_data_reg <= 8'd0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            stop_cnt_reg  <= stop_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            hold_data_reg <= hold_data_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic: frame sequencing, baud counting and the handshake.
    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        stop_cnt_next  = stop_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        hold_data_next = hold_data_reg;
        hold_full_next = hold_full_reg;
        tx_next        = tx_reg;
        done_next      = 1'b0;

        // Accept and load cannot happen on the same edge. Accept needs an
        // empty holding register, and load needs a full one.
        if (accept) begin
            hold_data_next = tx_data;
            hold_full_next = 1'b1;
        end

        // The baud counter wraps at the end of every bit and rests at 0
        // while the line is idle.
        if (state_reg == ST_IDLE) begin
            baud_cnt_next = 16'd0;
        end else if (bit_end) begin
            baud_cnt_next = 16'd0;
        end else begin
            baud_cnt_next = baud_cnt_reg + 16'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    state_next     = ST_START;
                    shift_next     = hold_data_reg;
                    parity_next    = hold_parity;
                    hold_full_next = 1'b0;
                    tx_next        = 1'b0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        if (PARITY != 0) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next    = ST_STOP;
                            stop_cnt_next = 1'b0;
                            tx_next       = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[bit_idx_reg + 3'd1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_next    = ST_STOP;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        done_next = 1'b1;
                        // A held byte starts its frame on this same edge,
                        // so no idle gap appears between frames.
                        if (hold_full_reg) begin
                            state_next     = ST_START;
                            shift_next     = hold_data_reg;
                            parity_next    = hold_parity;
                            hold_full_next = 1'b0;
                            tx_next        = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx with a bit time of
// 16 clocks. It uses three instances:
//   u_dut0: no parity, 1 stop bit
//   u_dut1: odd parity, 1 stop bit
//   u_dut2: even parity, 2 stop bits
module tb_uart_byte_tx;

    logic       clk;
    logic       rst;
    logic [2:0] vld;
    logic [7:0] dat [3];
    logic [2:0] rdy;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] line;

    int n_vec;
    int n_bad;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [23:0] bits;   // bit 0 = start bit, one entry per bit period
        int          nbits;
    } vec_t;

    vec_t vecs [8];

    uart_byte_tx #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_state(busy[0]), .tx_done(done[0]), .rs232_tx(line[0]));

    uart_byte_tx #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_state(busy[1]), .tx_done(done[1]), .rs232_tx(line[1]));

    uart_byte_tx #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_state(busy[2]), .tx_done(done[2]), .rs232_tx(line[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1 ms, required to end earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // The first edge S after the call is a START edge. For each cycle c,
    // sample at the negedge after edge S+c.
    task automatic check_frame(input string tag, input int sel, input logic [23:0] expb,
                               input int nbits, input int done_at, input bit toggle);
        int bad;
        bad = 0;
        for (int c = 0; c < nbits * 16; c++) begin
            @(negedge clk);
            if (c % 16 == 0) bad = 0;
            if (c == 0) chk($sformatf("%s ready_at_start", tag), 32'(rdy[sel]), 32'd1);
            if (toggle) begin
                if (c == 1) chk($sformatf("%s ready_while_held", tag), 32'(rdy[sel]), 32'd0);
                if (c >= 1 && c <= 158) begin
                    dat[sel] = 8'($urandom);
                    vld[sel] = 1'b1;
                end else if (c == 159) begin
                    vld[sel] = 1'b0;
                end
            end
            if (line[sel] !== expb[c / 16] || busy[sel] !== 1'b1 ||
                done[sel] !== (c == done_at))
                bad++;
            if (c % 16 == 8)
                chk($sformatf("%s bit%0d line", tag, c / 16), 32'(line[sel]), 32'(expb[c / 16]));
            if (c % 16 == 15)
                chk($sformatf("%s bit%0d bad_cycles", tag, c / 16), 32'(bad), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), 32'(done[sel]), 32'd1);
        chk($sformatf("%s state_after", tag), 32'(busy[sel]), 32'd0);
        chk($sformatf("%s line_after", tag), 32'(line[sel]), 32'd1);
        @(negedge clk);
        chk($sformatf("%s done_cleared", tag), 32'(done[sel]), 32'd0);
    endtask

    task automatic send_vec(input int idx);
        int sel;
        sel = vecs[idx].sel;
        @(negedge clk);
        dat[sel] = vecs[idx].data;
        vld[sel] = 1'b1;
        @(negedge clk);                       // just after the accept edge
        chk($sformatf("v%0d ready_after_accept", idx), 32'(rdy[sel]), 32'd0);
        vld[sel] = 1'b0;
        dat[sel] = ~vecs[idx].data;           // must not affect the frame
        check_frame($sformatf("v%0d", idx), sel, vecs[idx].bits, vecs[idx].nbits, -1, 1'b0);
        $display("vec %0d: dut%0d byte %02h frame of %0d bits", idx, sel,
                 vecs[idx].data, vecs[idx].nbits);
    endtask

    initial begin
        int bad_line, bad_done, bad_state;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        vld   = 3'b000;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;

        // Expected frames, written out by hand: {stop(s), parity, data, start}
        vecs[0] = '{0, 8'hA5, 24'({1'b1, 8'hA5, 1'b0}), 10};
        vecs[1] = '{0, 8'h00, 24'({1'b1, 8'h00, 1'b0}), 10};
        vecs[2] = '{0, 8'hFF, 24'({1'b1, 8'hFF, 1'b0}), 10};
        vecs[3] = '{1, 8'h03, 24'({1'b1, 1'b1, 8'h03, 1'b0}), 11};   // odd, 2 ones -> 1
        vecs[4] = '{1, 8'h07, 24'({1'b1, 1'b0, 8'h07, 1'b0}), 11};   // odd, 3 ones -> 0
        vecs[5] = '{1, 8'h00, 24'({1'b1, 1'b1, 8'h00, 1'b0}), 11};   // odd, 0 ones -> 1
        vecs[6] = '{2, 8'h03, 24'({2'b11, 1'b0, 8'h03, 1'b0}), 12};  // even, 2 ones -> 0
        vecs[7] = '{2, 8'h80, 24'({2'b11, 1'b1, 8'h80, 1'b0}), 12};  // even, 1 one -> 1

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d line", i),  32'(line[i]), 32'd1);
            chk($sformatf("reset dut%0d ready", i), 32'(rdy[i]),  32'd1);
            chk($sformatf("reset dut%0d state", i), 32'(busy[i]), 32'd0);
            chk($sformatf("reset dut%0d done", i),  32'(done[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle line after reset release", 32'(line[0]), 32'd1);

        for (int i = 0; i < 8; i++) send_vec(i);

        // Back-to-back 0x01 then 0x80 with tx_valid held. tx_data toggles
        // while the second byte is held.
        @(negedge clk);
        dat[0] = 8'h01;
        vld[0] = 1'b1;
        @(negedge clk);
        chk("b2b ready_after_first_accept", 32'(rdy[0]), 32'd0);
        dat[0] = 8'h80;
        check_frame("b2b", 0, {2'b00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0}, 20, 160, 1'b1);
        vld[0] = 1'b0;
        $display("seq b2b: dut0 bytes 01,80 back to back over 320 clocks");

        // Reset during DATA bit 3 while a second byte is held. tx_valid is
        // high on the reset edge.
        @(negedge clk);
        dat[0] = 8'h5A;
        vld[0] = 1'b1;
        @(negedge clk);
        dat[0] = 8'h3C;                       // held behind 0x5A
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) vld[0] = 1'b0;
            if (c == 70) begin
                chk("rst pre line (0x5A bit3)", 32'(line[0]), 32'd1);
                chk("rst pre ready (byte held)", 32'(rdy[0]), 32'd0);
                rst    = 1'b1;
                vld[0] = 1'b1;
                dat[0] = 8'h77;
            end
        end
        @(negedge clk);
        chk("rst line",  32'(line[0]), 32'd1);
        chk("rst state", 32'(busy[0]), 32'd0);
        chk("rst ready", 32'(rdy[0]),  32'd1);
        chk("rst done",  32'(done[0]), 32'd0);
        rst    = 1'b0;
        vld[0] = 1'b0;
        bad_line  = 0;
        bad_done  = 0;
        bad_state = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (line[0] !== 1'b1) bad_line++;
            if (done[0] !== 1'b0) bad_done++;
            if (busy[0] !== 1'b0) bad_state++;
        end
        chk("post-rst line never low",   32'(bad_line),  32'd0);
        chk("post-rst no tx_done",       32'(bad_done),  32'd0);
        chk("post-rst state stays idle", 32'(bad_state), 32'd0);
        $display("seq reset: dut0 reset at data bit 3, held byte discarded");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
